// File: rtl/kalman_pkg.sv
// Shared types and constants for the Kalman update scheduler: axis encoding,
// FSM state encoding, default watchdog sizing and the round-robin arbiter helpers.
package kalman_pkg;

    typedef enum logic [1:0] {
        AXIS_ROLL  = 2'd0,
        AXIS_PITCH = 2'd1,
        AXIS_YAW   = 2'd2
    } axis_t;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int DEF_TIMEOUT_CYCLES = 10;
    localparam int DEF_CNT_BITS       = 4;

    function automatic logic [2:0] axis_onehot(input axis_t a);
        logic [2:0] oh;
        oh = 3'b000;
        case (a)
            AXIS_ROLL:  oh = 3'b001;
            AXIS_PITCH: oh = 3'b010;
            AXIS_YAW:   oh = 3'b100;
            default:    oh = 3'b000;
        endcase
        return oh;
    endfunction

    // First pending axis strictly after 'last', wrapping round to 'last' itself.
    function automatic axis_t rr_pick(input axis_t last, input logic [2:0] pend);
        axis_t pick;
        pick = AXIS_ROLL;
        case (last)
            AXIS_ROLL: begin
                if (pend[1])      pick = AXIS_PITCH;
                else if (pend[2]) pick = AXIS_YAW;
                else              pick = AXIS_ROLL;
            end
            AXIS_PITCH: begin
                if (pend[2])      pick = AXIS_YAW;
                else if (pend[0]) pick = AXIS_ROLL;
                else              pick = AXIS_PITCH;
            end
            default: begin
                if (pend[0])      pick = AXIS_ROLL;
                else if (pend[1]) pick = AXIS_PITCH;
                else              pick = AXIS_YAW;
            end
        endcase
        return pick;
    endfunction

endpackage

// File: rtl/flex_counter.sv
// Up-counter with synchronous clear and a rollover strobe that fires in the
// cycle whose counting edge lands on rollover_val; the count wraps to zero there.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] count_q, count_d;
    logic [NUM_CNT_BITS-1:0] count_inc;

    assign count_inc     = count_q + NUM_CNT_BITS'(1);
    assign rollover_flag = count_enable && (count_inc == rollover_val);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            count_d = rollover_flag ? '0 : count_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/kalman_scheduler.sv
// Round-robin scheduler sharing one Kalman datapath between roll/pitch/yaw updates.
// Define KALMAN_SCHED_TIMEOUT_EN to add the BUSY watchdog and sticky timeout_err.
//   IDLE  | wait for a pending axis, pick the next one in rotation
//   START | one-cycle filt_start to the datapath
//   BUSY  | wait for filt_done (or watchdog expiry)
//   DONE  | pulse axis_done, retire the pending flag, record last grant
module kalman_scheduler
    import kalman_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_BITS       = DEF_CNT_BITS
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clear,
    input  logic [2:0] req,
    input  logic       filt_done,
    output logic       filt_start,
    output logic [1:0] filt_axis,
    output logic       busy,
    output logic [2:0] pending,
    output logic [2:0] axis_done,
    output logic       timeout_err
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (1 << CNT_BITS) - 1) begin : g_bad_timeout
        $error("kalman_scheduler: TIMEOUT_CYCLES does not fit the watchdog counter");
    end

    state_t     state_q, state_d;
    logic [2:0] pending_q, pending_d;
    axis_t      grant_q, grant_d;
    axis_t      last_grant_q, last_grant_d;
    logic       wd_expire;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        pending_d    = pending_q | req;
        case (state_q)
            ST_IDLE: begin
                if (pending_q != 3'b000) begin
                    grant_d = rr_pick(last_grant_q, pending_q);
                    state_d = ST_START;
                end
            end
            ST_START: state_d = ST_BUSY;
            ST_BUSY: begin
                if (filt_done || wd_expire) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // A same-cycle request on the retiring axis keeps it pending.
                pending_d    = (pending_q & ~axis_onehot(grant_q)) | req;
                last_grant_d = grant_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (clear) begin
            pending_d = 3'b000;
            state_d   = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q      <= ST_IDLE;
            pending_q    <= 3'b000;
            grant_q      <= AXIS_ROLL;
            last_grant_q <= AXIS_YAW;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

`ifdef KALMAN_SCHED_TIMEOUT_EN
    logic wd_rollover;
    logic timeout_err_q;

    // Cleared while in START so counting begins fresh on the first BUSY cycle.
    flex_counter #(
        .NUM_CNT_BITS(CNT_BITS)
    ) u_watchdog (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear || (state_q == ST_START)),
        .count_enable (state_q == ST_BUSY),
        .rollover_val (CNT_BITS'(TIMEOUT_CYCLES)),
        .rollover_flag(wd_rollover)
    );

    assign wd_expire = wd_rollover && !filt_done;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            timeout_err_q <= 1'b0;
        end else if (clear) begin
            timeout_err_q <= 1'b0;
        end else if ((state_q == ST_BUSY) && wd_expire) begin
            timeout_err_q <= 1'b1;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign wd_expire   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign filt_start = (state_q == ST_START);
    assign busy       = (state_q != ST_IDLE);
    assign filt_axis  = busy ? grant_q : 2'b00;
    assign pending    = pending_q;
    assign axis_done  = (state_q == ST_DONE) ? axis_onehot(grant_q) : 3'b000;

endmodule

// File: tb/tb_kalman_scheduler.sv
// Directed bench for kalman_scheduler: a per-cycle vector table plus hand
// sequences for fairness, abort and watchdog behaviour (KALMAN_SCHED_TIMEOUT_EN aware).
module tb_kalman_scheduler;

    logic       clk = 1'b0;
    logic       n_rst, clear, filt_done;
    logic [2:0] req;
    logic       filt_start, busy, timeout_err;
    logic [1:0] filt_axis;
    logic [2:0] pending, axis_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    kalman_scheduler #(
        .TIMEOUT_CYCLES(10),
        .CNT_BITS      (4)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .clear      (clear),
        .req        (req),
        .filt_done  (filt_done),
        .filt_start (filt_start),
        .filt_axis  (filt_axis),
        .busy       (busy),
        .pending    (pending),
        .axis_done  (axis_done),
        .timeout_err(timeout_err)
    );

    typedef struct packed {
        logic       rn;
        logic       cl;
        logic [2:0] rq;
        logic       dn;
        logic       st;
        logic [1:0] ax;
        logic       bz;
        logic [2:0] pd;
        logic [2:0] ad;
    } vec_t;

    localparam int NV = 36;
    vec_t vecs [NV];
    logic [1:0] exp_order [6];

    function automatic vec_t v(input logic rn, input logic cl, input logic [2:0] rq,
                               input logic dn, input logic st, input logic [1:0] ax,
                               input logic bz, input logic [2:0] pd, input logic [2:0] ad);
        vec_t r;
        r.rn = rn; r.cl = cl; r.rq = rq; r.dn = dn;
        r.st = st; r.ax = ax; r.bz = bz; r.pd = pd; r.ad = ad;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic rn, input logic cl, input logic [2:0] rq, input logic dn);
        n_rst     = rn;
        clear     = cl;
        req       = rq;
        filt_done = dn;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_start",   32'(filt_start),  32'd0);
        chk("rst_busy",    32'(busy),        32'd0);
        chk("rst_axis",    32'(filt_axis),   32'd0);
        chk("rst_pending", 32'(pending),     32'd0);
        chk("rst_done",    32'(axis_done),   32'd0);
        chk("rst_err",     32'(timeout_err), 32'd0);
        drive(1'b1, 1'b0, 3'b000, 1'b0);
    endtask

    initial begin
        drive(1'b0, 1'b0, 3'b000, 1'b0);

        //           rn    cl    req     dn  | st    ax     bz    pend    axis_done
        vecs[0]  = v(1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 3'b000);
        vecs[1]  = v(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 1'b0, 3'b001, 3'b000);
        vecs[2]  = v(1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 2'd0, 1'b1, 3'b001, 3'b000);
        vecs[3]  = v(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 1'b1, 3'b001, 3'b000);
        vecs[4]  = v(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 1'b1, 3'b001, 3'b000);
        vecs[5]  = v(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 1'b1, 3'b001, 3'b000);
        vecs[6]  = v(1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 2'd0, 1'b1, 3'b001, 3'b000);
        vecs[7]  = v(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 1'b1, 3'b001, 3'b001);
        vecs[8]  = v(1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 2'd0, 1'b0, 3'b000, 3'b000);
        vecs[9]  = v(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 3'b000);
        vecs[10] = v(1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 3'b000);
        vecs[11] = v(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000);
        vecs[12] = v(1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 2'd0, 1'b1, 3'b111, 3'b000);
        vecs[13] = v(1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 2'd0, 1'b1, 3'b111, 3'b000);
        vecs[14] = v(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 1'b1, 3'b111, 3'b001);
        vecs[15] = v(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 1'b0, 3'b110, 3'b000);
        vecs[16] = v(1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 2'd1, 1'b1, 3'b110, 3'b000);
        vecs[17] = v(1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 2'd1, 1'b1, 3'b110, 3'b000);
        vecs[18] = v(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd1, 1'b1, 3'b110, 3'b010);
        vecs[19] = v(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 1'b0, 3'b100, 3'b000);
        vecs[20] = v(1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 2'd2, 1'b1, 3'b100, 3'b000);
        vecs[21] = v(1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 2'd2, 1'b1, 3'b100, 3'b000);
        vecs[22] = v(1'b1, 1'b0, 3'b100, 1'b0, 1'b0, 2'd2, 1'b1, 3'b100, 3'b100);
        vecs[23] = v(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 1'b0, 3'b100, 3'b000);
        vecs[24] = v(1'b1, 1'b0, 3'b000, 1'b1, 1'b1, 2'd2, 1'b1, 3'b100, 3'b000);
        vecs[25] = v(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd2, 1'b1, 3'b100, 3'b000);
        vecs[26] = v(1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 2'd2, 1'b1, 3'b100, 3'b000);
        vecs[27] = v(1'b1, 1'b1, 3'b010, 1'b0, 1'b0, 2'd2, 1'b1, 3'b101, 3'b000);
        vecs[28] = v(1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 2'd0, 1'b0, 3'b000, 3'b000);
        vecs[29] = v(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 3'b000);
        vecs[30] = v(1'b1, 1'b0, 3'b010, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 3'b000);
        vecs[31] = v(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 1'b0, 3'b010, 3'b000);
        vecs[32] = v(1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 2'd1, 1'b1, 3'b010, 3'b000);
        vecs[33] = v(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'd1, 1'b1, 3'b010, 3'b000);
        vecs[34] = v(1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 2'd0, 1'b0, 3'b000, 3'b000);
        vecs[35] = v(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 3'b000);

        exp_order[0] = 2'd2; exp_order[1] = 2'd0; exp_order[2] = 2'd1;
        exp_order[3] = 2'd2; exp_order[4] = 2'd0; exp_order[5] = 2'd1;

        // Per-cycle table: outputs observed this cycle, inputs applied for this cycle's edge.
        do_reset();
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            chk($sformatf("v%0d_start", i),   32'(filt_start),  32'(vecs[i].st));
            chk($sformatf("v%0d_axis", i),    32'(filt_axis),   32'(vecs[i].ax));
            chk($sformatf("v%0d_busy", i),    32'(busy),        32'(vecs[i].bz));
            chk($sformatf("v%0d_pending", i), 32'(pending),     32'(vecs[i].pd));
            chk($sformatf("v%0d_done", i),    32'(axis_done),   32'(vecs[i].ad));
            chk($sformatf("v%0d_err", i),     32'(timeout_err), 32'd0);
            drive(vecs[i].rn, vecs[i].cl, vecs[i].rq, vecs[i].dn);
        end

        // Fairness: after a pitch grant, req=111 held with instant filt_done.
        begin : fairness
            int cyc, last_start, nstart;
            do_reset();
            @(negedge clk); drive(1'b1, 1'b0, 3'b010, 1'b0);
            @(negedge clk); drive(1'b1, 1'b0, 3'b000, 1'b0);
            @(negedge clk);
            chk("fair_pitch_start", 32'({filt_start, filt_axis}), 32'd5);
            drive(1'b1, 1'b0, 3'b111, 1'b1);
            cyc = 0; last_start = 0; nstart = 0;
            for (int i = 0; i < 40 && nstart < 6; i++) begin
                @(negedge clk);
                cyc++;
                if (filt_start) begin
                    chk($sformatf("fair_axis%0d", nstart), 32'(filt_axis), 32'(exp_order[nstart]));
                    chk($sformatf("fair_gap%0d", nstart), 32'(cyc - last_start), 32'd4);
                    last_start = cyc;
                    nstart++;
                end
            end
            chk("fair_count", 32'(nstart), 32'd6);
            drive(1'b1, 1'b0, 3'b000, 1'b0);
        end

        // Abort: roll completes, pitch job cleared with pending=110, last grant kept.
        begin : abort_seq
            do_reset();
            @(negedge clk); drive(1'b1, 1'b0, 3'b001, 1'b0);
            @(negedge clk); drive(1'b1, 1'b0, 3'b000, 1'b0);
            @(negedge clk); chk("ab_roll_start", 32'(filt_start), 32'd1);
            @(negedge clk); drive(1'b1, 1'b0, 3'b000, 1'b1);
            @(negedge clk); chk("ab_roll_done", 32'(axis_done), 32'd1);
            drive(1'b1, 1'b0, 3'b010, 1'b0);
            @(negedge clk); drive(1'b1, 1'b0, 3'b000, 1'b0);
            @(negedge clk); chk("ab_pitch_start", 32'({filt_start, filt_axis}), 32'd5);
            @(negedge clk); drive(1'b1, 1'b0, 3'b100, 1'b0);
            @(negedge clk);
            chk("ab_pend_before", 32'(pending), 32'd6);
            chk("ab_busy_before", 32'(busy), 32'd1);
            drive(1'b1, 1'b1, 3'b000, 1'b0);
            @(negedge clk);
            chk("ab_busy_after", 32'(busy), 32'd0);
            chk("ab_pend_after", 32'(pending), 32'd0);
            drive(1'b1, 1'b0, 3'b000, 1'b1);
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                chk($sformatf("ab_quiet%0d", i), 32'({busy, axis_done}), 32'd0);
            end
            drive(1'b1, 1'b0, 3'b111, 1'b0);
            @(negedge clk); drive(1'b1, 1'b0, 3'b000, 1'b0);
            @(negedge clk); chk("ab_next_grant", 32'({filt_start, filt_axis}), 32'd5);
        end

`ifdef KALMAN_SCHED_TIMEOUT_EN
        begin : watchdog
            int  nbusy;
            logic got;
            do_reset();
            @(negedge clk); drive(1'b1, 1'b0, 3'b001, 1'b0);
            @(negedge clk); drive(1'b1, 1'b0, 3'b000, 1'b0);
            @(negedge clk); chk("wd_start", 32'(filt_start), 32'd1);
            nbusy = 0; got = 1'b0;
            for (int i = 0; i < 30 && !got; i++) begin
                @(negedge clk);
                if (axis_done != 3'b000) got = 1'b1;
                else if (busy) nbusy++;
            end
            chk("wd_busy_cycles", 32'(nbusy), 32'd10);
            chk("wd_axis_done", 32'(axis_done), 32'd1);
            chk("wd_err_at_done", 32'(timeout_err), 32'd1);
            repeat (3) @(negedge clk);
            chk("wd_err_sticky", 32'(timeout_err), 32'd1);
            chk("wd_idle", 32'(busy), 32'd0);
            drive(1'b1, 1'b1, 3'b000, 1'b0);
            @(negedge clk);
            drive(1'b1, 1'b0, 3'b000, 1'b0);
            chk("wd_err_cleared", 32'(timeout_err), 32'd0);

            // filt_done on the limit cycle wins over the watchdog.
            @(negedge clk); drive(1'b1, 1'b0, 3'b010, 1'b0);
            @(negedge clk); drive(1'b1, 1'b0, 3'b000, 1'b0);
            @(negedge clk); chk("wd_tie_start", 32'(filt_start), 32'd1);
            nbusy = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (busy && axis_done == 3'b000) nbusy++;
                if (i == 9) filt_done = 1'b1;
            end
            @(negedge clk);
            filt_done = 1'b0;
            chk("wd_tie_busy", 32'(nbusy), 32'd10);
            chk("wd_tie_done", 32'(axis_done), 32'd2);
            chk("wd_tie_err", 32'(timeout_err), 32'd0);
        end
`else
        begin : no_watchdog
            int nbusy;
            do_reset();
            @(negedge clk); drive(1'b1, 1'b0, 3'b001, 1'b0);
            @(negedge clk); drive(1'b1, 1'b0, 3'b000, 1'b0);
            @(negedge clk); chk("nowd_start", 32'(filt_start), 32'd1);
            nbusy = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (busy && axis_done == 3'b000 && !filt_start) nbusy++;
            end
            chk("nowd_busy_held", 32'(nbusy), 32'd30);
            chk("nowd_err", 32'(timeout_err), 32'd0);
            drive(1'b1, 1'b1, 3'b000, 1'b0);
            @(negedge clk);
            drive(1'b1, 1'b0, 3'b000, 1'b0);
            chk("nowd_cleared", 32'(busy), 32'd0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/kalman_scheduler.md
KALMAN_SCHEDULER -- requirements
Module: kalman_scheduler

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 10: BUSY-cycle limit before the watchdog aborts (range 2..2^CNT_BITS-1).
REQ-002 Parameter CNT_BITS, default 4: width of the watchdog counter.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 n_rst  in  1  reset; synchronous, active-low.
REQ-005 clear  in  1  synchronous abort: drops all pending requests and the current job.
REQ-006 req  in  3  one-cycle update requests; bit0 roll, bit1 pitch, bit2 yaw.
REQ-007 filt_done  in  1  shared Kalman datapath finished the job in progress.
REQ-008 filt_start  out  1  one-cycle start pulse to the datapath.
REQ-009 filt_axis  out  2  axis of the current job, axis_t encoding, held from START through DONE.
REQ-010 busy  out  1  high in START, BUSY and DONE.
REQ-011 pending  out  3  registered pending-request flags, same bit order as req.
REQ-012 axis_done  out  3  one-cycle completion pulse for the serviced axis.
REQ-013 timeout_err  out  1  sticky watchdog flag.

Function
REQ-014 FSM states: IDLE, START, BUSY, DONE; one job in flight at a time.
REQ-015 req[i]=1 sets pending[i] at the next edge in any state; a repeated request on an already-pending axis merges (depth 1 per axis).
REQ-016 IDLE with pending!=0: grant the first pending axis in round-robin order after last_grant; go to START next edge. IDLE with pending==0: stay.
REQ-017 START: filt_start=1 for exactly one cycle, filt_axis=grant; go to BUSY.
REQ-018 BUSY: filt_done=1 goes to DONE; otherwise stay (watchdog per REQ-028).
REQ-019 DONE: axis_done[grant]=1, pending[grant] cleared, last_grant<=grant; go to IDLE.
REQ-020 req on the granted axis during DONE keeps pending set (set beats clear); that axis re-runs later in rotation order.
REQ-021 filt_done outside BUSY is ignored.
REQ-022 Latency: req pulse in cycle 0 with FSM idle and nothing pending gives filt_start in cycle 2; filt_done in cycle k gives axis_done in cycle k+1.
REQ-023 Minimum spacing between filt_start pulses: 4 cycles (START, BUSY, DONE, IDLE).
REQ-024 clear=1: pending<=0, state<=IDLE, watchdog counter<=0, timeout_err<=0; last_grant unchanged; clear beats a same-cycle req; no axis_done for the aborted job.

Reset
REQ-025 n_rst=0 at an edge: state=IDLE, pending=0, last_grant=yaw (so roll wins first), counter=0; all outputs 0.
REQ-026 Reset mid-job aborts silently; filt_start, busy and axis_done stay low until new requests arrive after release.

Configuration
REQ-027 Macro KALMAN_SCHED_TIMEOUT_EN selects the watchdog.
REQ-028 Defined: counter clears on entry to BUSY and counts each BUSY cycle; reaching TIMEOUT_CYCLES without filt_done forces DONE (axis_done still pulsed) and sets timeout_err until clear or reset; filt_done in the same cycle as the limit wins and sets no error.
REQ-029 Undefined: no counter; BUSY waits indefinitely; timeout_err tied to 0; port list identical.

Structure
REQ-030 Shared package kalman_pkg holds typedef axis_t (ROLL=0, PITCH=1, YAW=2), the FSM state typedef and the default TIMEOUT_CYCLES constant.
REQ-031 The watchdog uses one instance of the team's existing flex_counter (NUM_CNT_BITS=CNT_BITS, rollover_val=TIMEOUT_CYCLES), present only under the macro.

Verification
REQ-032 Single roll request: req=001 at cycle 0 -> filt_start with filt_axis=0 at cycle 2; filt_done at cycle 6 -> axis_done=001 at cycle 7; pending returns to 000.
REQ-033 Simultaneous requests: req=111 from reset -> grants in order roll, pitch, yaw; three axis_done pulses in that order.
REQ-034 Fairness: after a pitch grant, req=111 held continuously -> grant order yaw, roll, pitch, repeating.
REQ-035 Watchdog (macro on, TIMEOUT_CYCLES=10): no filt_done -> DONE after 10 BUSY cycles, timeout_err=1 until clear; with the macro off, busy stays 1 indefinitely.
REQ-036 Abort: clear during BUSY with pending=110 -> IDLE next cycle, pending=000, no axis_done pulse; a later filt_done is ignored.
